md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the P7 MIPS pipeline, owning the HI/LO registers.
- Executes the commands the main controller issues on MDControl/Start: mult, multu, div, divu, mthi, mtlo.
- Raises Busy while an operation is in flight. The hazard unit combines Busy and Start with the controller's MD_Stall to hold dependent instructions.
- HI and LO are exported continuously; the EX output mux selects them for mfhi/mflo.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_if.sv | 15 +
 rtl/md_calc.sv | 46 ++++
 rtl/md_unit.sv | 82 ++++++++
 tb/tb_md_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MDControl encodings and default latencies.
// Used by md_unit, the main controller and the hazard unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int CNT_W       = 8;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage multiply/divide bundle: operands and command in, Busy and HI/LO out.
// master is the pipeline side, slave is md_unit.
interface md_if;
    logic [31:0] D1;
    logic [31:0] D2;
    logic [2:0]  MDControl;
    logic        Start;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output D1, D2, MDControl, Start, Req, input Busy, HI, LO);
    modport slave  (input D1, D2, MDControl, Start, Req, output Busy, HI, LO);
endinterface

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and divide/remainder, signed or unsigned per op.
// Result is {HI,LO}; o_div0 flags a zero divisor (result then meaningless).
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [63:0] o_res,
    output logic        o_div0
);
    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);

    // Low 64 bits of the product of the extended operands are exact for both signednesses.
    assign w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
    assign w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Magnitude divide avoids the 0x80000000 / -1 overflow corner of a native signed divide.
    assign w_a_neg = w_signed & i_a[31];
    assign w_b_neg = w_signed & i_b[31];
    assign w_a_mag = w_a_neg ? (-i_a) : i_a;
    assign w_b_mag = w_b_neg ? (-i_b) : i_b;
    assign o_div0  = (i_b == 32'd0);
    assign w_den   = o_div0 ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
    assign w_r     = w_a_neg ? (-w_r_mag) : w_r_mag;

    assign o_res = is_div_op(i_op) ? {w_r, w_q} : w_prod;
endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency ops with Busy.
// mthi/mtlo write in zero cycles; commands in RUN or with Req=1 are dropped.
module md_unit #(
    parameter int MULT_CYCLES = md_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = md_pkg::DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);
    import md_pkg::*;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_op;
    logic [63:0]      w_res;
    logic             w_div0;

    md_calc u_calc (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .o_res  (w_res),
        .o_div0 (w_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= MD_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!md.Req) begin
                        if (md.Start && is_md_op(md.MDControl)) begin
                            r_a     <= md.D1;
                            r_b     <= md.D2;
                            r_op    <= md.MDControl;
                            r_cnt   <= is_div_op(md.MDControl) ? CNT_W'(DIV_CYCLES)
                                                               : CNT_W'(MULT_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end else if (md.MDControl == MD_MTHI) begin
                            r_hi <= md.D1;
                        end else if (md.MDControl == MD_MTLO) begin
                            r_lo <= md.D1;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        // A zero divisor burns the full latency but leaves HI/LO intact.
                        if (!(is_div_op(r_op) && w_div0)) begin
                            {r_hi, r_lo} <= w_res;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md.Busy = r_busy;
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: cycle-level reference model compared every cycle,
// plus literal HI/LO/Busy-length expectations for each scenario.
module tb_md_unit;
    logic clk;
    logic reset;
    logic cmp_en;
    int   checks;
    int   failures;

    md_if u_if ();

    md_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_res;
    logic        m_wr;
    int          m_left;

    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        logic [31:0] uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = 64'd0;
        case (op)
            3'd1: p = sa * sb;
            3'd2: p = ua * ub;
            3'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) begin
                uq = a / b;
                ur = a % b;
                p  = {ur, uq};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
            m_wr   <= 1'b0;
            m_res  <= 64'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end else if (!u_if.Req) begin
            if (u_if.Start && u_if.MDControl >= 3'd1 && u_if.MDControl <= 3'd4) begin
                m_res  <= ref_calc(u_if.MDControl, u_if.D1, u_if.D2);
                m_wr   <= !(u_if.MDControl >= 3'd3 && u_if.D2 == 32'd0);
                m_left <= (u_if.MDControl >= 3'd3) ? 10 : 5;
            end else if (u_if.MDControl == 3'd5) begin
                m_hi <= u_if.D1;
            end else if (u_if.MDControl == 3'd6) begin
                m_lo <= u_if.D1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'b0, u_if.Busy}, {31'b0, (m_left != 0)});
            chk("model_hi", u_if.HI, m_hi);
            chk("model_lo", u_if.LO, m_lo);
        end
    end

    // Present a command for exactly one rising edge, starting from a negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic st, input logic rq);
        u_if.MDControl = op;
        u_if.D1        = d1;
        u_if.D2        = d2;
        u_if.Start     = st;
        u_if.Req       = rq;
        @(negedge clk);
        u_if.MDControl = 3'd0;
        u_if.Start     = 1'b0;
        u_if.Req       = 1'b0;
    endtask

    task automatic wait_busy(input string name, input int exp, input int already);
        int n;
        n = already;
        while (u_if.Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
    endtask

    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        cmp_en         = 1'b0;
        checks         = 0;
        failures       = 0;
        u_if.D1        = 32'd0;
        u_if.D2        = 32'd0;
        u_if.MDControl = 3'd0;
        u_if.Start     = 1'b0;
        u_if.Req       = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", {31'b0, u_if.Busy}, 32'd0);
        chk("rst_hi", u_if.HI, 32'd0);
        chk("rst_lo", u_if.LO, 32'd0);

        // mult -3 * 5
        issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        wait_busy("mult_busy_len", 5, 0);
        chk("mult_hi", u_if.HI, 32'hFFFFFFFF);
        chk("mult_lo", u_if.LO, 32'hFFFFFFF1);

        // multu, operands scrambled during RUN
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        u_if.D1 = 32'hDEAD0000;
        u_if.D2 = 32'd9;
        wait_busy("multu_busy_len", 5, 0);
        chk("multu_hi", u_if.HI, 32'h00000001);
        chk("multu_lo", u_if.LO, 32'hFFFFFFFE);

        // div -7 / 2
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        wait_busy("div_busy_len", 10, 0);
        chk("div_hi", u_if.HI, 32'hFFFFFFFF);
        chk("div_lo", u_if.LO, 32'hFFFFFFFD);

        // divu by zero leaves HI/LO
        issue(3'd4, 32'h55, 32'd0, 1'b1, 1'b0);
        wait_busy("div0_busy_len", 10, 0);
        chk("div0_hi", u_if.HI, 32'hFFFFFFFF);
        chk("div0_lo", u_if.LO, 32'hFFFFFFFD);

        // signed overflow corner
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        wait_busy("ovf_busy_len", 10, 0);
        chk("ovf_hi", u_if.HI, 32'h00000000);
        chk("ovf_lo", u_if.LO, 32'h80000000);

        // mthi, then mtlo cancelled by Req
        issue(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
        chk("mthi_busy", {31'b0, u_if.Busy}, 32'd0);
        chk("mthi_hi", u_if.HI, 32'h12345678);
        issue(3'd6, 32'h0000CAFE, 32'd0, 1'b0, 1'b1);
        chk("mtlo_req_lo", u_if.LO, 32'h80000000);

        // reserved / none with Start
        issue(3'd7, 32'd3, 32'd3, 1'b1, 1'b0);
        chk("rsvd_busy", {31'b0, u_if.Busy}, 32'd0);
        issue(3'd0, 32'd3, 32'd3, 1'b1, 1'b0);
        chk("none_busy", {31'b0, u_if.Busy}, 32'd0);

        // Start with Req
        issue(3'd1, 32'd3, 32'd3, 1'b1, 1'b1);
        chk("req_busy", {31'b0, u_if.Busy}, 32'd0);
        chk("req_hi", u_if.HI, 32'h12345678);
        chk("req_lo", u_if.LO, 32'h80000000);

        // div 100/7 with Start and mtlo pulsed mid-run
        issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        u_if.MDControl = 3'd1;
        u_if.Start     = 1'b1;
        u_if.D1        = 32'd2;
        u_if.D2        = 32'd2;
        @(negedge clk);
        u_if.MDControl = 3'd6;
        u_if.Start     = 1'b0;
        u_if.D1        = 32'h0000CAFE;
        @(negedge clk);
        u_if.MDControl = 3'd0;
        wait_busy("run_ign_busy_len", 10, 5);
        chk("run_ign_hi", u_if.HI, 32'd2);
        chk("run_ign_lo", u_if.LO, 32'd14);

        // divu with Req mid-run still completes
        issue(3'd4, 32'd100, 32'd9, 1'b1, 1'b0);
        u_if.Req = 1'b1;
        @(negedge clk);
        u_if.Req = 1'b0;
        wait_busy("divu_req_busy_len", 10, 1);
        chk("divu_hi", u_if.HI, 32'd1);
        chk("divu_lo", u_if.LO, 32'd11);

        // reset mid-divide, then a fresh mult
        issue(3'd3, 32'd1000, 32'd3, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, u_if.Busy}, 32'd0);
        chk("midrst_hi", u_if.HI, 32'd0);
        chk("midrst_lo", u_if.LO, 32'd0);
        issue(3'd1, 32'd7, 32'd6, 1'b1, 1'b0);
        wait_busy("postrst_busy_len", 5, 0);
        chk("postrst_hi", u_if.HI, 32'd0);
        chk("postrst_lo", u_if.LO, 32'd42);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
